// File: rtl/lpif_asym_pkg.sv
// Shared lane geometry, beat type and bundle field helpers for the quarter-rate
// upstream LPIF unpacker.
package lpif_asym_pkg;

   localparam int LANES    = 4;
   localparam int DATA_W   = 128;
   localparam int STATE_W  = 4;
   localparam int PROTID_W = 2;
   localparam int CRC_W    = 8;
   localparam int BUNDLE_W = 580;

   // Bundle bit layout, LSB first: state, protid, data, dvalid, crc, crc_valid, valid
   localparam int STATE_LSB  = 0;
   localparam int PROTID_LSB = STATE_LSB + LANES * STATE_W;
   localparam int DATA_LSB   = PROTID_LSB + LANES * PROTID_W;
   localparam int DVALID_LSB = DATA_LSB + LANES * DATA_W;
   localparam int CRC_LSB    = DVALID_LSB + LANES;
   localparam int CRCV_LSB   = CRC_LSB + LANES * CRC_W;
   localparam int VALID_LSB  = CRCV_LSB + LANES;

   typedef struct packed {
      logic [STATE_W-1:0]  state;
      logic [PROTID_W-1:0] protid;
      logic [DATA_W-1:0]   data;
      logic                dvalid;
      logic [CRC_W-1:0]    crc;
      logic                crc_valid;
   } lpif_beat_t;

   function automatic logic [LANES-1:0] bundle_valid(input logic [BUNDLE_W-1:0] bundle);
      return bundle[VALID_LSB +: LANES];
   endfunction

   function automatic lpif_beat_t bundle_lane(input logic [BUNDLE_W-1:0] bundle,
                                              input logic [1:0] lane);
      lpif_beat_t beat;
      beat.state     = bundle[STATE_LSB  + STATE_W  * int'(lane) +: STATE_W];
      beat.protid    = bundle[PROTID_LSB + PROTID_W * int'(lane) +: PROTID_W];
      beat.data      = bundle[DATA_LSB   + DATA_W   * int'(lane) +: DATA_W];
      beat.dvalid    = bundle[DVALID_LSB + int'(lane)];
      beat.crc       = bundle[CRC_LSB    + CRC_W    * int'(lane) +: CRC_W];
      beat.crc_valid = bundle[CRCV_LSB   + int'(lane)];
      return beat;
   endfunction

endpackage

// File: rtl/lpif_bundle_fifo.sv
// Single-clock bundle FIFO with flush; a push into a full FIFO is accepted only
// when the same cycle pops the head.
module lpif_bundle_fifo #(
   parameter int WIDTH = 580,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)
            count <= count + CNT_W'(1);
         else if (!do_push && do_pop)
            count <= count - CNT_W'(1);
      end
   end

   // Storage needs no reset; emptiness is tracked by the pointers and count
   always_ff @(posedge clk) begin
      if (do_push && !rst && !flush) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/lpif_ustrm_quarter_unpacker.sv
// Buffers quarter-rate upstream LPIF bundles and serializes their valid lanes
// into one flit beat per cycle, counting bundles dropped on overflow.
module lpif_ustrm_quarter_unpacker
   import lpif_asym_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic         clk_wr,
   input  logic         rst_wr,
   input  logic         rx_online,
   input  logic [15:0]  ustrm_state,
   input  logic [7:0]   ustrm_protid,
   input  logic [511:0] ustrm_data,
   input  logic [3:0]   ustrm_dvalid,
   input  logic [31:0]  ustrm_crc,
   input  logic [3:0]   ustrm_crc_valid,
   input  logic [3:0]   ustrm_valid,
   output logic         beat_valid,
   input  logic         beat_ready,
   output logic [3:0]   beat_state,
   output logic [1:0]   beat_protid,
   output logic [127:0] beat_data,
   output logic         beat_dvalid,
   output logic [7:0]   beat_crc,
   output logic         beat_crc_valid,
   input  logic         ovf_clr,
   output logic [31:0]  unpack_debug_status
);

   logic [BUNDLE_W-1:0] bundle_in;
   logic [BUNDLE_W-1:0] head;
   logic [LANES-1:0]    head_valid;
   logic                fifo_full;
   logic                fifo_empty;
   logic [CNT_W-1:0]    occupancy;
   logic                push_req;
   logic                pop;
   logic                drop;
   logic [1:0]          ptr;
   logic [1:0]          sel;
   logic                found;
   logic                last;
   lpif_beat_t          lane_beat;
   logic                sticky;
   logic [15:0]         drop_cnt;

   assign bundle_in = {ustrm_valid, ustrm_crc_valid, ustrm_crc, ustrm_dvalid,
                       ustrm_data, ustrm_protid, ustrm_state};
   assign push_req  = rx_online && (|ustrm_valid);
   assign pop       = beat_valid && beat_ready && last;
   assign drop      = push_req && fifo_full && !pop;

   lpif_bundle_fifo #(
      .WIDTH (BUNDLE_W),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk   (clk_wr),
      .rst   (rst_wr),
      .push  (push_req),
      .pop   (pop),
      .flush (!rx_online),
      .wdata (bundle_in),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (occupancy)
   );

   assign head_valid = bundle_valid(head);

   // Pick the lowest valid lane at or above the pointer; last means none follows it
   always_comb begin
      sel   = '0;
      found = 1'b0;
      last  = 1'b1;
      for (int i = 0; i < LANES; i++) begin
         if (head_valid[i] && (i >= int'(ptr))) begin
            if (!found) begin
               sel   = 2'(i);
               found = 1'b1;
            end else begin
               last = 1'b0;
            end
         end
      end
   end

   always_comb begin
      lane_beat      = bundle_lane(head, sel);
      beat_valid     = !fifo_empty;
      beat_state     = '0;
      beat_protid    = '0;
      beat_data      = '0;
      beat_dvalid    = 1'b0;
      beat_crc       = '0;
      beat_crc_valid = 1'b0;
      if (!fifo_empty) begin
         beat_state     = lane_beat.state;
         beat_protid    = lane_beat.protid;
         beat_data      = lane_beat.data;
         beat_dvalid    = lane_beat.dvalid;
         beat_crc       = lane_beat.crc;
         beat_crc_valid = lane_beat.crc_valid;
      end
   end

   always_ff @(posedge clk_wr) begin
      if (rst_wr || !rx_online)
         ptr <= '0;
      else if (beat_valid && beat_ready)
         ptr <= last ? 2'd0 : sel + 2'd1;
   end

   // Clear wins over a drop in the same cycle
   always_ff @(posedge clk_wr) begin
      if (rst_wr || ovf_clr) begin
         sticky   <= 1'b0;
         drop_cnt <= '0;
      end else if (drop) begin
         sticky <= 1'b1;
         if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
   end

   always_comb begin
      unpack_debug_status              = '0;
      unpack_debug_status[CNT_W-1:0]   = occupancy;
      unpack_debug_status[8]           = sticky;
      unpack_debug_status[9]           = fifo_empty;
      unpack_debug_status[10]          = fifo_full;
      unpack_debug_status[31:16]       = drop_cnt;
   end

endmodule

// File: tb/tb_lpif_ustrm_quarter_unpacker.sv
// Self-checking bench: directed scenarios plus random traffic compared against a
// queue-based model of buffered bundles and consumed lanes.
module tb_lpif_ustrm_quarter_unpacker;

   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [3:0]   valid;
      logic [3:0]   crc_valid;
      logic [31:0]  crc;
      logic [3:0]   dvalid;
      logic [511:0] data;
      logic [7:0]   protid;
      logic [15:0]  state;
   } bundle_t;

   logic         clk_wr = 1'b0;
   logic         rst_wr;
   logic         rx_online;
   logic         beat_ready;
   logic         ovf_clr;
   bundle_t      drv;
   logic         beat_valid;
   logic [3:0]   beat_state;
   logic [1:0]   beat_protid;
   logic [127:0] beat_data;
   logic         beat_dvalid;
   logic [7:0]   beat_crc;
   logic         beat_crc_valid;
   logic [31:0]  unpack_debug_status;
   wire  [144:0] beat_vec = {beat_valid, beat_state, beat_protid, beat_data,
                             beat_dvalid, beat_crc, beat_crc_valid};

   bundle_t      q[$];
   logic [3:0]   consumed;
   logic         sticky_m;
   logic [15:0]  drops_m;
   int           errors = 0;
   int           checks = 0;

   always #5 clk_wr = ~clk_wr;

   lpif_ustrm_quarter_unpacker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk_wr              (clk_wr),
      .rst_wr              (rst_wr),
      .rx_online           (rx_online),
      .ustrm_state         (drv.state),
      .ustrm_protid        (drv.protid),
      .ustrm_data          (drv.data),
      .ustrm_dvalid        (drv.dvalid),
      .ustrm_crc           (drv.crc),
      .ustrm_crc_valid     (drv.crc_valid),
      .ustrm_valid         (drv.valid),
      .beat_valid          (beat_valid),
      .beat_ready          (beat_ready),
      .beat_state          (beat_state),
      .beat_protid         (beat_protid),
      .beat_data           (beat_data),
      .beat_dvalid         (beat_dvalid),
      .beat_crc            (beat_crc),
      .beat_crc_valid      (beat_crc_valid),
      .ovf_clr             (ovf_clr),
      .unpack_debug_status (unpack_debug_status)
   );

   function automatic bundle_t rand_bundle(input logic [3:0] valid);
      logic [607:0] raw;
      bundle_t      b;
      for (int w = 0; w < 19; w++) raw[32*w +: 32] = $urandom;
      b = raw[579:0];
      b.valid = valid;
      return b;
   endfunction

   function automatic int head_lane();
      bundle_t    h;
      logic [3:0] rem;
      h   = q[0];
      rem = h.valid & ~consumed;
      for (int i = 0; i < 4; i++) if (rem[i]) return i;
      return 0;
   endfunction

   function automatic logic [144:0] exp_beat();
      bundle_t h;
      int      l;
      if (q.size() == 0) return '0;
      h = q[0];
      l = head_lane();
      return {1'b1, h.state[4*l +: 4], h.protid[2*l +: 2], h.data[128*l +: 128],
              h.dvalid[l], h.crc[8*l +: 8], h.crc_valid[l]};
   endfunction

   function automatic logic [31:0] exp_status();
      logic [31:0] s;
      s              = '0;
      s[CNT_W-1:0]   = CNT_W'(q.size());
      s[8]           = sticky_m;
      s[9]           = (q.size() == 0);
      s[10]          = (q.size() == DEPTH);
      s[31:16]       = drops_m;
      return s;
   endfunction

   // Model of one clock edge using the inputs currently driven
   task automatic model_edge();
      logic drop;
      int   l;
      drop = 1'b0;
      if (rst_wr) begin
         q.delete();
         consumed = '0;
         sticky_m = 1'b0;
         drops_m  = '0;
         return;
      end
      if (!rx_online) begin
         q.delete();
         consumed = '0;
      end else begin
         if (q.size() > 0 && beat_ready) begin
            l = head_lane();
            consumed[l] = 1'b1;
            if ((q[0].valid & ~consumed) == 4'b0000) begin
               void'(q.pop_front());
               consumed = '0;
            end
         end
         if (drv.valid != 4'b0000) begin
            if (q.size() < DEPTH) q.push_back(drv);
            else drop = 1'b1;
         end
      end
      if (ovf_clr) begin
         sticky_m = 1'b0;
         drops_m  = '0;
      end else if (drop) begin
         sticky_m = 1'b1;
         if (drops_m != 16'hFFFF) drops_m = drops_m + 16'd1;
      end
   endtask

   task automatic tick();
      @(posedge clk_wr);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      rst_wr = 1'b1;
      drv    = rand_bundle(4'b1111);
      tick();
      tick();
      checks++;
      if (beat_vec !== 145'd0) begin
         errors++;
         $display("[TB] FAIL reset_beat: got %h want 0", beat_vec);
      end
      checks++;
      if (unpack_debug_status !== 32'h0000_0200) begin
         errors++;
         $display("[TB] FAIL reset_status: got %h want 00000200", unpack_debug_status);
      end
      rst_wr = 1'b0;
      drv    = '0;
      tick();
   endtask

   task automatic test_four_lanes();
      drv            = rand_bundle(4'b1111);
      drv.data       = {128'd3, 128'd2, 128'd1, 128'd0};
      beat_ready     = 1'b1;
      tick();
      drv = '0;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (!beat_valid || beat_data !== 128'(k)) begin
            errors++;
            $display("[TB] FAIL four_lanes_data%0d: got valid=%b data=%h want data=%0d", k, beat_valid, beat_data, k);
         end
         checks++;
         if (beat_vec !== exp_beat()) begin
            errors++;
            $display("[TB] FAIL four_lanes_beat%0d: got %h want %h", k, beat_vec, exp_beat());
         end
         tick();
      end
      checks++;
      if (beat_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL four_lanes_drain: got valid=%b want 0", beat_valid);
      end
   endtask

   task automatic test_sparse();
      bundle_t b;
      b          = rand_bundle(4'b1010);
      drv        = b;
      beat_ready = 1'b1;
      tick();
      drv = '0;
      checks++;
      if (!beat_valid || beat_state !== b.state[7:4] || beat_crc !== b.crc[15:8]) begin
         errors++;
         $display("[TB] FAIL sparse_lane1: got v=%b st=%h crc=%h want st=%h crc=%h", beat_valid, beat_state, beat_crc, b.state[7:4], b.crc[15:8]);
      end
      tick();
      checks++;
      if (!beat_valid || beat_state !== b.state[15:12] || beat_crc !== b.crc[31:24] || beat_data !== b.data[511:384]) begin
         errors++;
         $display("[TB] FAIL sparse_lane3: got v=%b st=%h crc=%h want st=%h crc=%h", beat_valid, beat_state, beat_crc, b.state[15:12], b.crc[31:24]);
      end
      tick();
      checks++;
      if (beat_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL sparse_drain: got valid=%b want 0", beat_valid);
      end
   endtask

   task automatic test_overflow();
      logic [144:0] held;
      beat_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         drv = rand_bundle(4'b1111);
         tick();
      end
      drv  = '0;
      held = beat_vec;
      checks++;
      if (unpack_debug_status !== 32'h0001_0504) begin
         errors++;
         $display("[TB] FAIL overflow_status: got %h want 00010504", unpack_debug_status);
      end
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      checks++;
      if (unpack_debug_status !== 32'h0000_0404) begin
         errors++;
         $display("[TB] FAIL overflow_clear: got %h want 00000404", unpack_debug_status);
      end
      checks++;
      if (beat_vec !== held || beat_vec !== exp_beat()) begin
         errors++;
         $display("[TB] FAIL overflow_hold: got %h want %h", beat_vec, exp_beat());
      end
   endtask

   task automatic test_full_pop_push();
      rst_wr = 1'b1;
      tick();
      rst_wr     = 1'b0;
      beat_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drv = rand_bundle(4'b0100);
         tick();
      end
      drv        = rand_bundle(4'b1111);
      beat_ready = 1'b1;
      tick();
      drv        = '0;
      beat_ready = 1'b0;
      checks++;
      if (unpack_debug_status !== 32'h0000_0404) begin
         errors++;
         $display("[TB] FAIL full_pop_push_status: got %h want 00000404", unpack_debug_status);
      end
      checks++;
      if (beat_vec !== exp_beat()) begin
         errors++;
         $display("[TB] FAIL full_pop_push_beat: got %h want %h", beat_vec, exp_beat());
      end
   endtask

   task automatic test_offline();
      rst_wr = 1'b1;
      tick();
      rst_wr     = 1'b0;
      beat_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         drv = rand_bundle(4'b1111);
         tick();
      end
      drv        = '0;
      beat_ready = 1'b1;
      tick();
      beat_ready = 1'b0;
      checks++;
      if (beat_vec !== exp_beat() || beat_state !== q[0].state[7:4]) begin
         errors++;
         $display("[TB] FAIL offline_lane1: got %h want %h", beat_vec, exp_beat());
      end
      rx_online = 1'b0;
      drv       = rand_bundle(4'b1111);
      tick();
      rx_online = 1'b1;
      drv       = '0;
      checks++;
      if (beat_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL offline_flush_valid: got %b want 0", beat_valid);
      end
      checks++;
      if (unpack_debug_status !== 32'h0001_0300) begin
         errors++;
         $display("[TB] FAIL offline_status: got %h want 00010300", unpack_debug_status);
      end
   endtask

   task automatic test_reset_midstream();
      beat_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drv = rand_bundle(4'($urandom_range(1, 15)));
         tick();
      end
      drv = '0;
      checks++;
      if (unpack_debug_status !== exp_status()) begin
         errors++;
         $display("[TB] FAIL midstream_queued: got %h want %h", unpack_debug_status, exp_status());
      end
      rst_wr = 1'b1;
      tick();
      rst_wr = 1'b0;
      checks++;
      if (beat_valid !== 1'b0 || unpack_debug_status !== 32'h0000_0200) begin
         errors++;
         $display("[TB] FAIL midstream_reset: got valid=%b status=%h want 0 00000200", beat_valid, unpack_debug_status);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         drv        = rand_bundle(($urandom % 3 == 0) ? 4'b0000 : 4'($urandom));
         beat_ready = ($urandom % 3 != 0);
         rx_online  = ($urandom % 20 != 0);
         ovf_clr    = ($urandom % 25 == 0);
         tick();
         checks++;
         if (beat_vec !== exp_beat()) begin
            errors++;
            $display("[TB] FAIL random_beat%0d: got %h want %h", n, beat_vec, exp_beat());
         end
         checks++;
         if (unpack_debug_status !== exp_status()) begin
            errors++;
            $display("[TB] FAIL random_status%0d: got %h want %h", n, unpack_debug_status, exp_status());
         end
      end
      drv       = '0;
      rx_online = 1'b1;
      ovf_clr   = 1'b0;
   endtask

   initial begin
      rst_wr     = 1'b1;
      rx_online  = 1'b1;
      beat_ready = 1'b0;
      ovf_clr    = 1'b0;
      drv        = '0;
      consumed   = '0;
      sticky_m   = 1'b0;
      drops_m    = '0;
      test_reset();
      test_four_lanes();
      test_sparse();
      test_overflow();
      test_full_pop_push();
      test_offline();
      test_reset_midstream();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
